target_reset_monitor: RTL and testbench



---
 rtl/target_reset_monitor_pkg.sv | 44 ++++
 rtl/target_reset_monitor_sync_glitch_filter.sv | 97 +++++++++
 rtl/target_reset_monitor.sv | 260 ++++++++++++++++++++++++++
 tb/tb_target_reset_monitor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/target_reset_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : target_reset_monitor_pkg
//  Description : Shared definitions for the target reset monitor: register
//                command codes, FSM state encoding and a byte-lane read
//                helper used by the register read mux.
//  Revision    : 1.0  initial release
// ============================================================================
package target_reset_monitor_pkg;

    // Register bus command codes
    localparam logic [7:0] TARGET_RESET_MON_CTRL   = 8'h70;
    localparam logic [7:0] TARGET_RESET_MON_FILTER = 8'h71;
    localparam logic [7:0] TARGET_RESET_MON_STATUS = 8'h72;
    localparam logic [7:0] TARGET_RESET_MON_COUNT  = 8'h73;
    localparam logic [7:0] TARGET_RESET_MON_WIDTH  = 8'h74;

    // MON_CTRL bit positions
    localparam int c_CTRL_ARM   = 0;
    localparam int c_CTRL_POL   = 1;
    localparam int c_CTRL_AUTO  = 2;
    localparam int c_CTRL_CLEAR = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_ASSERTED = 2'd2
    } mon_state_t;

    // Returns byte 'idx' of 'value' (LSB = byte 0), or 0 when idx is at or
    // beyond the register's byte count. nbytes never exceeds 8.
    function automatic logic [7:0] byte_sel(input logic [63:0]   value,
                                            input logic [15:0]   idx,
                                            input int unsigned   nbytes);
        logic [63:0] v_shift;
        byte_sel = 8'h00;
        v_shift  = value >> {idx[2:0], 3'b000};
        if (32'(idx) < nbytes) begin
            byte_sel = v_shift[7:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/target_reset_monitor_sync_glitch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : target_reset_monitor_sync_glitch_filter
//  Description : Synchroniser plus programmable glitch filter for an
//                asynchronous target input pin. The synchronised value is
//                optionally inverted so that 1 always means "active". The
//                filtered level changes only after i_filter_len+1 consecutive
//                cycles of disagreement; one-cycle rise/fall strobes follow
//                each change of the filtered level by one cycle.
//  Revision    : 1.0  initial release
//
//  Ports:
//    clk          in   sole clock
//    rst_n        in   asynchronous active-low reset
//    i_pin        in   raw asynchronous pin
//    i_invert     in   1 = pin is active-low
//    i_filter_len in   filter length (0 = one cycle)
//    i_cnt_clr    in   clears the disagreement counter
//    o_level      out  filtered level, 1 = active
//    o_rise       out  one-cycle strobe after filtered level went 0->1
//    o_fall       out  one-cycle strobe after filtered level went 1->0
// ============================================================================
module target_reset_monitor_sync_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int LEN_BITS    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_pin,
    input  logic                i_invert,
    input  logic [LEN_BITS-1:0] i_filter_len,
    input  logic                i_cnt_clr,
    output logic                o_level,
    output logic                o_rise,
    output logic                o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [LEN_BITS-1:0]    r_cnt;
    logic                   r_level;
    logic                   r_level_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sample;
    logic                   w_differ;

    assign w_sample = r_sync[SYNC_STAGES-1] ^ i_invert;
    assign w_differ = (w_sample != r_level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    // The counter counts disagreeing cycles already seen; when it has reached
    // the programmed length, the current disagreeing cycle is the
    // (len+1)-th one and the level flips. '>=' guards against a length
    // lowered below an in-progress count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_cnt_clr) begin
            r_cnt   <= '0;
        end else if (w_differ) begin
            if (r_cnt >= i_filter_len) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt   <= r_cnt + LEN_BITS'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
            r_fall    <= ~r_level & r_level_d;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/target_reset_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : target_reset_monitor
//  Description : Watches the reset line returned by the target. The pin is
//                synchronised and glitch-filtered; while armed, each
//                qualified assertion produces a one-cycle reset_event, bumps
//                a saturating event counter and has its width measured in
//                clk_usb cycles. Controlled over the serial register bus.
//  Revision    : 1.0  initial release
//
//  Ports:
//    clk_usb          in   sole clock
//    reset_n          in   asynchronous active-low reset
//    reg_cmd[7:0]     in   command selector
//    reg_bytecount    in   byte index within register, 0 = LSB
//    reg_data_in[7:0] in   write data
//    reg_data_out     out  read data (combinational, 0 when not reading)
//    reg_read         in   read strobe
//    reg_write        in   write strobe
//    target_reset_in  in   raw asynchronous reset pin from the target
//    reset_event      out  one-cycle pulse on qualified assertion while armed
// ============================================================================
module target_reset_monitor
    import target_reset_monitor_pkg::*;
#(
    parameter int         SYNC_STAGES    = 2,
    parameter int         COUNT_BITS     = 16,
    parameter int         WIDTH_BITS     = 32,
    parameter logic [7:0] FILTER_DEFAULT = 8'd4
) (
    input  logic        clk_usb,
    input  logic        reset_n,
    input  logic [7:0]  reg_cmd,
    input  logic [15:0] reg_bytecount,
    input  logic [7:0]  reg_data_in,
    output logic [7:0]  reg_data_out,
    input  logic        reg_read,
    input  logic        reg_write,
    input  logic        target_reset_in,
    output logic        reset_event
);

    localparam int unsigned c_COUNT_BYTES = (COUNT_BITS + 7) / 8;
    localparam int unsigned c_WIDTH_BYTES = (WIDTH_BITS + 7) / 8;

    // Control / configuration registers
    logic                  r_arm;
    logic                  r_pol;
    logic                  r_auto;
    logic [7:0]            r_filter_len;

    // Measurement state
    mon_state_t            r_state;
    logic [COUNT_BITS-1:0] r_count;
    logic [WIDTH_BITS-1:0] r_width_cnt;
    logic [WIDTH_BITS-1:0] r_width_lat;
    logic                  r_done;
    logic                  r_ovf;
    logic                  r_event;

    // Decode and FSM outputs
    logic                  w_wr0;
    logic                  w_ctrl_wr;
    logic                  w_filter_wr;
    logic                  w_clear;
    logic                  w_level;
    logic                  w_rise;
    logic                  w_fall;
    mon_state_t            w_state_nxt;
    logic                  w_arm_nxt;
    logic                  w_fire;
    logic                  w_latch;
    logic                  w_width_run;
    logic                  w_count_sat;
    logic                  w_width_sat;
    logic [7:0]            w_ctrl_rd;
    logic [7:0]            w_status_rd;

    // ------------------------------------------------------------------
    // Register write decode (only byte 0 of writable registers exists)
    // ------------------------------------------------------------------
    assign w_wr0       = reg_write && (reg_bytecount == 16'd0);
    assign w_ctrl_wr   = w_wr0 && (reg_cmd == TARGET_RESET_MON_CTRL);
    assign w_filter_wr = w_wr0 && (reg_cmd == TARGET_RESET_MON_FILTER);
    assign w_clear     = w_ctrl_wr && reg_data_in[c_CTRL_CLEAR];

    // ------------------------------------------------------------------
    // Pin conditioning; polarity 0 means the pin is active-low
    // ------------------------------------------------------------------
    target_reset_monitor_sync_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .LEN_BITS    (8)
    ) u_filter (
        .clk          (clk_usb),
        .rst_n        (reset_n),
        .i_pin        (target_reset_in),
        .i_invert     (~r_pol),
        .i_filter_len (r_filter_len),
        .i_cnt_clr    (w_filter_wr),
        .o_level      (w_level),
        .o_rise       (w_rise),
        .o_fall       (w_fall)
    );

    // ------------------------------------------------------------------
    // FSM next state. Arming from IDLE while the line is already asserted
    // lands in ARMED, which only reacts to a rise strobe, so a pre-existing
    // assertion must deassert before it can be reported.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_arm_nxt   = r_arm;
        w_fire      = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
            end
            ST_ARMED: begin
                if (w_rise) begin
                    w_fire      = 1'b1;
                    w_state_nxt = ST_ASSERTED;
                end
            end
            ST_ASSERTED: begin
                if (w_fall) begin
                    w_latch = 1'b1;
                    if (r_auto) begin
                        w_state_nxt = ST_ARMED;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_arm_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Software arm control overrides the autonomous transitions. A
        // disarm discards any event or width being produced this cycle.
        if (w_ctrl_wr) begin
            w_arm_nxt = reg_data_in[c_CTRL_ARM];
            if (!reg_data_in[c_CTRL_ARM]) begin
                w_state_nxt = ST_IDLE;
                w_fire      = 1'b0;
                w_latch     = 1'b0;
            end else if (w_state_nxt == ST_IDLE) begin
                w_state_nxt = ST_ARMED;
            end
        end
    end

    assign w_width_run = (r_state == ST_ASSERTED) && (w_state_nxt == ST_ASSERTED);
    assign w_count_sat = &r_count;
    assign w_width_sat = &r_width_cnt;

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_arm   <= 1'b0;
            r_event <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_arm   <= w_arm_nxt;
            r_event <= w_fire;
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            r_pol        <= 1'b0;
            r_auto       <= 1'b0;
            r_filter_len <= FILTER_DEFAULT;
        end else begin
            if (w_ctrl_wr) begin
                r_pol  <= reg_data_in[c_CTRL_POL];
                r_auto <= reg_data_in[c_CTRL_AUTO];
            end
            if (w_filter_wr) begin
                r_filter_len <= reg_data_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters and latched results; clear takes priority over any
    // same-cycle increment or latch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_clear) begin
            r_count <= '0;
        end else if (w_fire && !w_count_sat) begin
            r_count <= r_count + COUNT_BITS'(1);
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            r_width_cnt <= '0;
        end else if (w_fire) begin
            r_width_cnt <= WIDTH_BITS'(1);
        end else if (w_width_run && !w_width_sat) begin
            r_width_cnt <= r_width_cnt + WIDTH_BITS'(1);
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            r_width_lat <= '0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_clear) begin
            r_width_lat <= '0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_latch) begin
                r_width_lat <= r_width_cnt;
                r_done      <= 1'b1;
            end
            if (w_width_run && w_width_sat) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign reset_event = r_event;

    // ------------------------------------------------------------------
    // Register read mux (side-effect free)
    // ------------------------------------------------------------------
    assign w_ctrl_rd   = {5'b0, r_auto, r_pol, r_arm};
    assign w_status_rd = {2'b0, w_count_sat, r_ovf, r_done,
                          (r_state == ST_ASSERTED), r_arm, w_level};

    always_comb begin
        reg_data_out = 8'h00;
        if (reg_read) begin
            case (reg_cmd)
                TARGET_RESET_MON_CTRL:
                    reg_data_out = byte_sel(64'(w_ctrl_rd), reg_bytecount, 1);
                TARGET_RESET_MON_FILTER:
                    reg_data_out = byte_sel(64'(r_filter_len), reg_bytecount, 1);
                TARGET_RESET_MON_STATUS:
                    reg_data_out = byte_sel(64'(w_status_rd), reg_bytecount, 1);
                TARGET_RESET_MON_COUNT:
                    reg_data_out = byte_sel(64'(r_count), reg_bytecount, c_COUNT_BYTES);
                TARGET_RESET_MON_WIDTH:
                    reg_data_out = byte_sel(64'(r_width_lat), reg_bytecount, c_WIDTH_BYTES);
                default:
                    reg_data_out = 8'h00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_target_reset_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_target_reset_monitor
//  Description : Self-checking bench for target_reset_monitor. Expected
//                reset_event cycles are queued when the pin is driven and
//                popped when the DUT pulses; register contents are checked
//                against values derived from the intended behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_target_reset_monitor;
    import target_reset_monitor_pkg::*;

    logic        clk_usb = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  reg_cmd = 8'h00;
    logic [15:0] reg_bytecount = 16'h0000;
    logic [7:0]  reg_data_in = 8'h00;
    logic [7:0]  reg_data_out;
    logic        reg_read = 1'b0;
    logic        reg_write = 1'b0;
    logic        target_reset_in = 1'b1;
    logic        reset_event;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int exp_q[$];
    int c;

    always #5 clk_usb = ~clk_usb;

    target_reset_monitor dut (
        .clk_usb         (clk_usb),
        .reset_n         (reset_n),
        .reg_cmd         (reg_cmd),
        .reg_bytecount   (reg_bytecount),
        .reg_data_in     (reg_data_in),
        .reg_data_out    (reg_data_out),
        .reg_read        (reg_read),
        .reg_write       (reg_write),
        .target_reset_in (target_reset_in),
        .reset_event     (reset_event)
    );

    always @(posedge clk_usb) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every pulse must match the oldest expected cycle.
    always @(negedge clk_usb) begin
        if (reset_event) begin
            if (exp_q.size() == 0) chk("unexpected_event", 32'(cyc), 32'hFFFF_FFFF);
            else                   chk("event_cycle", 32'(cyc), 32'(exp_q.pop_front()));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_usb);
    endtask

    task automatic wr(input logic [7:0] cmd, input logic [15:0] bc, input logic [7:0] data);
        reg_cmd       = cmd;
        reg_bytecount = bc;
        reg_data_in   = data;
        reg_write     = 1'b1;
        @(negedge clk_usb);
        reg_write     = 1'b0;
    endtask

    task automatic rd(input logic [7:0] cmd, input logic [15:0] bc, input logic [7:0] exp,
                      input string tag);
        reg_cmd       = cmd;
        reg_bytecount = bc;
        reg_read      = 1'b1;
        #1;
        chk(tag, 32'(reg_data_out), 32'(exp));
        reg_read      = 1'b0;
        @(negedge clk_usb);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk_usb);
        chk("rst_event_low", 32'(reset_event), 32'd0);
        reset_n = 1'b1;
        step(5);
        rd(TARGET_RESET_MON_FILTER, 16'd0, 8'd4,  "rst_filter");
        rd(TARGET_RESET_MON_CTRL,   16'd0, 8'h00, "rst_ctrl");
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h00, "rst_status");
        rd(TARGET_RESET_MON_COUNT,  16'd0, 8'h00, "rst_count0");
        rd(TARGET_RESET_MON_WIDTH,  16'd0, 8'h00, "rst_width0");

        // Writes to a non-zero byte are ignored; reads need reg_read.
        wr(TARGET_RESET_MON_FILTER, 16'd1, 8'h09);
        rd(TARGET_RESET_MON_FILTER, 16'd0, 8'd4, "filter_bc1_ignored");
        reg_cmd = TARGET_RESET_MON_FILTER; reg_bytecount = 16'd0; reg_read = 1'b0;
        #1 chk("read_strobe_off", 32'(reg_data_out), 32'd0);
        step(1);
        rd(8'hFF, 16'd0, 8'h00, "unknown_cmd");

        // ---------------- arm, glitch rejection ----------------
        wr(TARGET_RESET_MON_CTRL, 16'd0, 8'h01);
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h02, "armed_status");
        target_reset_in = 1'b0;
        step(3);
        target_reset_in = 1'b1;
        step(20);
        rd(TARGET_RESET_MON_COUNT,  16'd0, 8'h00, "glitch_count");
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h02, "glitch_status");

        // ---------------- latency and 1000-cycle width ----------------
        c = cyc;
        target_reset_in = 1'b0;
        exp_q.push_back(c + 9);          // sampling edge c+1, plus 2+4+2
        step(9);
        rd(TARGET_RESET_MON_COUNT,  16'd0, 8'h01, "lat_count");
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h07, "lat_status");
        step(989);
        target_reset_in = 1'b1;
        step(20);
        rd(TARGET_RESET_MON_WIDTH,  16'd0, 8'hE8, "width_b0");
        rd(TARGET_RESET_MON_WIDTH,  16'd1, 8'h03, "width_b1");
        rd(TARGET_RESET_MON_WIDTH,  16'd2, 8'h00, "width_b2");
        rd(TARGET_RESET_MON_WIDTH,  16'd3, 8'h00, "width_b3");
        rd(TARGET_RESET_MON_WIDTH,  16'd4, 8'h00, "width_b4_oor");
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h08, "done_status");
        rd(TARGET_RESET_MON_CTRL,   16'd0, 8'h00, "auto_disarm_ctrl");

        // Not re-armed: a new assertion must not produce an event.
        target_reset_in = 1'b0;
        step(30);
        target_reset_in = 1'b1;
        step(30);
        rd(TARGET_RESET_MON_COUNT, 16'd0, 8'h01, "idle_no_count");

        // ---------------- auto re-arm, clear racing the 5th event ----------------
        wr(TARGET_RESET_MON_CTRL, 16'd0, 8'h0D);
        rd(TARGET_RESET_MON_COUNT,  16'd0, 8'h00, "clear_count");
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h02, "clear_status");
        for (int i = 0; i < 5; i++) begin
            c = cyc;
            target_reset_in = 1'b0;
            exp_q.push_back(c + 9);
            if (i == 4) begin
                step(8);
                wr(TARGET_RESET_MON_CTRL, 16'd0, 8'h0D);   // active while the event fires
                step(11);
            end else begin
                step(20);
            end
            target_reset_in = 1'b1;
            step(30);
            if (i == 3) begin
                rd(TARGET_RESET_MON_COUNT, 16'd0, 8'h04, "auto_count4");
                rd(TARGET_RESET_MON_WIDTH, 16'd0, 8'd20, "auto_width20");
            end
        end
        rd(TARGET_RESET_MON_COUNT,  16'd0, 8'h00, "clear_wins_count");
        rd(TARGET_RESET_MON_WIDTH,  16'd0, 8'd20, "post_clear_width");
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h0A, "auto_status");

        // ---------------- disarm mid-assertion ----------------
        wr(TARGET_RESET_MON_CTRL, 16'd0, 8'h05);
        c = cyc;
        target_reset_in = 1'b0;
        exp_q.push_back(c + 9);
        step(20);
        wr(TARGET_RESET_MON_CTRL, 16'd0, 8'h00);
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h09, "disarm_status");
        step(20);
        target_reset_in = 1'b1;
        step(20);
        rd(TARGET_RESET_MON_WIDTH,  16'd0, 8'd20, "disarm_width_kept");
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h08, "disarm_status_after");

        // ---------------- pin already asserted when armed ----------------
        target_reset_in = 1'b0;
        step(20);
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h09, "pre_assert_status");
        wr(TARGET_RESET_MON_CTRL, 16'd0, 8'h01);
        step(20);
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h0B, "pre_assert_armed");
        target_reset_in = 1'b1;
        step(20);
        c = cyc;
        target_reset_in = 1'b0;
        exp_q.push_back(c + 9);
        step(20);
        target_reset_in = 1'b1;
        step(20);
        rd(TARGET_RESET_MON_COUNT,  16'd0, 8'h02, "fresh_count");
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h08, "fresh_status");

        // ---------------- shorter filter, then reset mid-assertion ----------------
        wr(TARGET_RESET_MON_FILTER, 16'd0, 8'd2);
        wr(TARGET_RESET_MON_CTRL,   16'd0, 8'h05);
        c = cyc;
        target_reset_in = 1'b0;
        exp_q.push_back(c + 7);          // sampling edge c+1, plus 2+2+2
        step(10);
        #2 reset_n = 1'b0;
        #1 chk("mid_rst_event", 32'(reset_event), 32'd0);
        step(2);
        reset_n = 1'b1;
        rd(TARGET_RESET_MON_STATUS, 16'd0, 8'h00, "mid_rst_status");
        rd(TARGET_RESET_MON_FILTER, 16'd0, 8'd4,  "mid_rst_filter");
        rd(TARGET_RESET_MON_CTRL,   16'd0, 8'h00, "mid_rst_ctrl");
        rd(TARGET_RESET_MON_COUNT,  16'd0, 8'h00, "mid_rst_count0");
        rd(TARGET_RESET_MON_COUNT,  16'd1, 8'h00, "mid_rst_count1");
        rd(TARGET_RESET_MON_WIDTH,  16'd0, 8'h00, "mid_rst_width0");
        target_reset_in = 1'b1;
        step(20);

        chk("pending_events", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
